// File: rtl/sound_env_ctrl_if.sv
// rtl/sound_env_ctrl_if.sv - register write bus for NRx2/NRx4 into the envelope control block
interface sound_env_ctrl_if;
  logic       nrx2_wr;
  logic [7:0] nrx2_data;
  logic       nrx4_wr;
  logic [7:0] nrx4_data;

  modport master (output nrx2_wr, output nrx2_data, output nrx4_wr, output nrx4_data);
  modport slave  (input  nrx2_wr, input  nrx2_data, input  nrx4_wr, input  nrx4_data);
endinterface

// File: rtl/sound_env_ctrl.sv
// rtl/sound_env_ctrl.sv - 512 Hz frame sequencer, NRx2 register and trigger-to-start conversion
module sound_env_ctrl #(
  parameter int CLK_DIV = 8192
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   apu_en,
  sound_env_ctrl_if.slave        bus,
  output logic                   tick_length,
  output logic                   tick_sweep,
  output logic                   clk_vol_env,
  output logic                   start,
  output logic [3:0]             initial_volume,
  output logic                   envelope_increasing,
  output logic [2:0]             num_envelope_sweeps,
  output logic                   dac_en,
  output logic                   channel_on
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [2:0]       step;
  logic [7:0]       nrx2_q;

  logic       term;
  logic       trig;
  logic [7:0] nrx2_next;
  logic       dac_next;
  logic       start_next;
  logic       env_due;
  logic       unused_nrx4;

  assign unused_nrx4 = ^bus.nrx4_data[6:0];

  // The envelope-side fields are plain views of the NRx2 flop.
  assign initial_volume      = nrx2_q[7:4];
  assign envelope_increasing = nrx2_q[3];
  assign num_envelope_sweeps = nrx2_q[2:0];

  // Next-state terms: a same-cycle NRx2 write takes precedence so a trigger sees the new DAC state.
  always_comb begin
    term       = (div == DIV_MAX);
    trig       = bus.nrx4_wr & bus.nrx4_data[7];
    nrx2_next  = bus.nrx2_wr ? bus.nrx2_data : nrx2_q;
    dac_next   = |nrx2_next[7:3];
    start_next = trig & dac_next;
    env_due    = term & (step == 3'd7);
  end

  // Divider, step counter, tick pulses, NRx2 register and channel state; apu_en low holds everything at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      step        <= '0;
      nrx2_q      <= '0;
      tick_length <= 1'b0;
      tick_sweep  <= 1'b0;
      clk_vol_env <= 1'b0;
      start       <= 1'b0;
      dac_en      <= 1'b0;
      channel_on  <= 1'b0;
    end else if (!apu_en) begin
      div         <= '0;
      step        <= '0;
      nrx2_q      <= '0;
      tick_length <= 1'b0;
      tick_sweep  <= 1'b0;
      clk_vol_env <= 1'b0;
      start       <= 1'b0;
      dac_en      <= 1'b0;
      channel_on  <= 1'b0;
    end else begin
      div         <= term ? '0 : div + 1'b1;
      step        <= term ? step + 3'd1 : step;
      tick_length <= term & ~step[0];
      tick_sweep  <= term & (step[1:0] == 2'b10);
      // An envelope clock that would land on the start cycle is dropped for this step.
      clk_vol_env <= env_due & ~start_next;
      nrx2_q      <= nrx2_next;
      dac_en      <= dac_next;
      start       <= start_next;
      channel_on  <= dac_next & (channel_on | start_next);
    end
  end

endmodule

// File: doc/sound_env_ctrl.md
Name: sound_env_ctrl

Overview:
Control-side driver for the channel volume-envelope unit. It contains the 512 Hz frame sequencer and produces single-cycle length, sweep and envelope ticks. It also holds the NRx2 envelope register and converts NRx4 trigger writes into a clean start pulse. Its outputs connect directly to the envelope unit's clk_vol_env, start, initial_volume, envelope_increasing and num_envelope_sweeps inputs.

Parameters:
CLK_DIV, 8192, system clocks per frame-sequencer step (4.194304 MHz / 512 Hz); minimum 2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
apu_en  in  1  master sound enable (NR52 bit 7); low holds the block idle
nrx2_wr  in  1  one-cycle write strobe for NRx2
nrx2_data  in  8  NRx2 write data: [7:4] initial volume, [3] increase, [2:0] sweep count
nrx4_wr  in  1  one-cycle write strobe for NRx4
nrx4_data  in  8  NRx4 write data; bit 7 is the trigger
tick_length  out  1  one-cycle pulse on frame steps 0, 2, 4, 6
tick_sweep  out  1  one-cycle pulse on frame steps 2, 6
clk_vol_env  out  1  one-cycle pulse on frame step 7 (envelope clock)
start  out  1  one-cycle registered trigger pulse to the envelope unit
initial_volume  out  4  registered NRx2[7:4]
envelope_increasing  out  1  registered NRx2[3]
num_envelope_sweeps  out  3  registered NRx2[2:0]
dac_en  out  1  high when NRx2[7:3] != 0
channel_on  out  1  channel active flag

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; NRx2 register 0; divider 0; step 0; pending-trigger flag 0. All outputs are driven from flops. No combinational path runs from any input to any output.
- Divider: counts 0..CLK_DIV-1 while apu_en=1, then wraps to 0. At terminal count with current step S:
  - tick_length is asserted on the next cycle if S is even.
  - tick_sweep is asserted on the next cycle if S is 2 or 6.
  - clk_vol_env is asserted on the next cycle if S is 7.
  - step becomes (S+1) mod 8.
  - Each pulse lasts exactly one cycle.
- The first event after reset or after apu_en rises is step 0, so tick_length asserts CLK_DIV cycles after the enable edge.
- apu_en=0:
  - Divider and step are forced to 0.
  - NRx2 register, channel_on and dac_en are cleared.
  - All pulses are held low.
  - nrx2_wr and nrx4_wr are ignored.
- NRx2 write: on nrx2_wr, the register loads nrx2_data. Outputs initial_volume, envelope_increasing, num_envelope_sweeps and dac_en update on the next cycle.
- dac_en falling clears channel_on in the same cycle dac_en updates.
- Trigger: nrx4_wr with nrx4_data[7]=1 sets a pending flag.
  - On the next cycle, if dac_en=1: start=1 for one cycle, channel_on=1, pending cleared.
  - If dac_en=0: pending cleared, start stays 0, channel_on stays 0.
  - Latency from the trigger write to start is 1 cycle.
  - nrx4_wr with bit 7=0 has no effect.
- Simultaneous NRx2 write and trigger in the same cycle: the start pulse uses the newly written NRx2 values, and the dac_en check uses the new value.
- Envelope tick coinciding with start (both due in the same cycle): clk_vol_env is suppressed for that step and not replayed. This guarantees the envelope unit never sees a clock edge while start is high.
- Retrigger while channel_on=1: start pulses again with the same 1-cycle latency; channel_on stays 1.
- apu_en falling with a trigger pending: the pending flag is cleared and no start pulse is issued.
- rst_n asserted mid-sequence: everything returns to reset values immediately. The sequence restarts at step 0 after release.
- The frame sequencer runs regardless of channel_on. Ticks are emitted whenever apu_en=1.

Test Plan:
- CLK_DIV=4, apu_en=1 from reset release → tick_length at cycle 4. Sequence over 32 cycles:
  - tick_length on steps 0, 2, 4, 6 (4 pulses).
  - tick_sweep on steps 2, 6.
  - clk_vol_env once, at the cycle following step 7's terminal count; repeats every 32 cycles.
- Write NRx2=0xA3, then NRx4=0x80 → one cycle later: start=1 for 1 cycle, initial_volume=0xA, envelope_increasing=0, num_envelope_sweeps=3, dac_en=1, channel_on=1.
- NRx2=0x00 (dac_en=0), then NRx4=0x80 → start never asserts, channel_on=0. A subsequent NRx2=0x08 write keeps dac_en=1 and a later trigger succeeds.
- NRx2=0xF8 and NRx4=0x80 in the same cycle → start next cycle with initial_volume=0xF, envelope_increasing=1.
- Trigger timed so start coincides with the step-7 tick → clk_vol_env stays 0 that step; the next clk_vol_env arrives 8 steps later.
- Mid-run apu_en=0 then 1 → all outputs 0 while low; first tick_length CLK_DIV cycles after re-enable. Also pull rst_n low mid-step → outputs 0 immediately, asynchronously.
